// File: rtl/fir_seq_ctrl.sv
// FIR sequencer: sample strobe -> coefficient read burst + EnMul/EnAddAcc, and the coefficient-update write protocol.
// All outputs registered; pass = TAPS+3 cycles, strobes outside IDLE are dropped, write words stall via valid/ready.
module fir_seq_ctrl #(
  parameter int TAPS   = 10,
  parameter int TAP_W  = 4,
  parameter int BANK_W = 2
) (
  input  logic                      iClk12M,
  input  logic                      iRsn,
  input  logic                      iEnSample600k,
  input  logic [BANK_W-1:0]         iBankSel,
  input  logic                      iUpdReq,
  input  logic [BANK_W-1:0]         iUpdBank,
  input  logic                      iCoeffWrValid,
  input  logic [15:0]               iCoeffWrData,
  output logic                      oCoeffWrReady,
  output logic                      oUpdAck,
  output logic                      oCoeffUpdateFlag,
  output logic                      oCsnRam,
  output logic                      oWrnRam,
  output logic [BANK_W+TAP_W-1:0]   oAddrRam,
  output logic [15:0]               oWtDtRam,
  output logic                      oEnMul,
  output logic                      oEnAddAcc,
  output logic                      oBusy,
  output logic                      oPassDone,
  output logic                      oSampleMiss
);

  localparam int AW = BANK_W + TAP_W;
  localparam logic [TAP_W-1:0] LP_LAST = TAP_W'(TAPS - 1);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RUN,
    ST_TAIL,
    ST_UPD_PRE,
    ST_UPD_WR,
    ST_UPD_POST
  } state_t;

  state_t            r_state, w_state_nxt;
  logic [TAP_W-1:0]  r_tap, w_tap_nxt;
  logic [TAP_W-1:0]  r_wcnt, w_wcnt_nxt;
  logic [1:0]        r_cnt, w_cnt_nxt;
  logic [BANK_W-1:0] r_bank, w_bank_nxt;
  logic [BANK_W-1:0] r_upd_bank, w_upd_bank_nxt;
  logic [TAP_W-1:0]  r_wr_tap;
  logic [15:0]       r_wr_dat;
  logic              r_wr_pend;
  logic              r_run_d;
  logic              r_tail_done, w_tail_done_nxt;
  logic              w_acc;
  logic              w_ack_nxt, w_rdy_nxt, w_flag_nxt;
  logic              w_csn_nxt, w_wrn_nxt;
  logic [AW-1:0]     w_addr_nxt;
  logic [15:0]       w_wdat_nxt;

  assign w_acc = (r_state == ST_UPD_WR) && oCoeffWrReady && iCoeffWrValid;

  always_ff @(posedge iClk12M) begin
    if (!iRsn) r_state <= ST_IDLE;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt     = r_state;
    w_tap_nxt       = r_tap;
    w_wcnt_nxt      = r_wcnt;
    w_cnt_nxt       = r_cnt;
    w_bank_nxt      = r_bank;
    w_upd_bank_nxt  = r_upd_bank;
    w_tail_done_nxt = 1'b0;
    w_ack_nxt       = 1'b0;
    w_rdy_nxt       = 1'b0;
    w_flag_nxt      = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (iEnSample600k) begin
          w_state_nxt = ST_RUN;
          w_tap_nxt   = '0;
          w_bank_nxt  = iBankSel;
        // Grant waits out the pass-done cycle so the host sees done before ack.
        end else if (iUpdReq && !r_tail_done) begin
          w_state_nxt    = ST_UPD_PRE;
          w_ack_nxt      = 1'b1;
          w_upd_bank_nxt = iUpdBank;
        end
      end
      ST_RUN: begin
        if (r_tap == LP_LAST) begin
          w_state_nxt = ST_TAIL;
          w_cnt_nxt   = '0;
        end else begin
          w_tap_nxt = r_tap + 1'b1;
        end
      end
      ST_TAIL: begin
        if (r_cnt == 2'd1) begin
          w_state_nxt     = ST_IDLE;
          w_tail_done_nxt = 1'b1;
        end else begin
          w_cnt_nxt = r_cnt + 2'd1;
        end
      end
      ST_UPD_PRE: begin
        w_flag_nxt  = 1'b1;
        w_state_nxt = ST_UPD_WR;
        w_wcnt_nxt  = '0;
        w_rdy_nxt   = 1'b1;
      end
      ST_UPD_WR: begin
        w_flag_nxt = 1'b1;
        w_rdy_nxt  = 1'b1;
        if (w_acc) begin
          if (r_wcnt == LP_LAST) begin
            w_state_nxt = ST_UPD_POST;
            w_cnt_nxt   = '0;
            w_rdy_nxt   = 1'b0;
          end else begin
            w_wcnt_nxt = r_wcnt + 1'b1;
          end
        end
      end
      ST_UPD_POST: begin
        w_flag_nxt = 1'b1;
        if (r_cnt == 2'd2) w_state_nxt = ST_IDLE;
        else               w_cnt_nxt   = r_cnt + 2'd1;
      end
      default: w_state_nxt = ST_IDLE;
    endcase

    // RAM port: reads during RUN, else the write captured on the previous acceptance.
    w_csn_nxt  = 1'b1;
    w_wrn_nxt  = 1'b1;
    w_addr_nxt = '0;
    w_wdat_nxt = oWtDtRam;
    if (r_state == ST_RUN) begin
      w_csn_nxt  = 1'b0;
      w_addr_nxt = {r_bank, r_tap};
    end else if (r_wr_pend) begin
      w_csn_nxt  = 1'b0;
      w_wrn_nxt  = 1'b0;
      w_addr_nxt = {r_upd_bank, r_wr_tap};
      w_wdat_nxt = r_wr_dat;
    end
  end

  always_ff @(posedge iClk12M) begin
    if (!iRsn) begin
      r_tap            <= '0;
      r_wcnt           <= '0;
      r_cnt            <= '0;
      r_bank           <= '0;
      r_upd_bank       <= '0;
      r_wr_tap         <= '0;
      r_wr_dat         <= '0;
      r_wr_pend        <= 1'b0;
      r_run_d          <= 1'b0;
      r_tail_done      <= 1'b0;
      oCoeffWrReady    <= 1'b0;
      oUpdAck          <= 1'b0;
      oCoeffUpdateFlag <= 1'b0;
      oCsnRam          <= 1'b1;
      oWrnRam          <= 1'b1;
      oAddrRam         <= '0;
      oWtDtRam         <= '0;
      oEnMul           <= 1'b0;
      oEnAddAcc        <= 1'b0;
      oBusy            <= 1'b0;
      oPassDone        <= 1'b0;
      oSampleMiss      <= 1'b0;
    end else begin
      r_tap            <= w_tap_nxt;
      r_wcnt           <= w_wcnt_nxt;
      r_cnt            <= w_cnt_nxt;
      r_bank           <= w_bank_nxt;
      r_upd_bank       <= w_upd_bank_nxt;
      r_wr_pend        <= w_acc;
      if (w_acc) begin
        r_wr_tap <= r_wcnt;
        r_wr_dat <= iCoeffWrData;
      end
      r_run_d          <= (r_state == ST_RUN);
      r_tail_done      <= w_tail_done_nxt;
      oCoeffWrReady    <= w_rdy_nxt;
      oUpdAck          <= w_ack_nxt;
      oCoeffUpdateFlag <= w_flag_nxt;
      oCsnRam          <= w_csn_nxt;
      oWrnRam          <= w_wrn_nxt;
      oAddrRam         <= w_addr_nxt;
      oWtDtRam         <= w_wdat_nxt;
      oEnMul           <= r_run_d;
      oEnAddAcc        <= oEnMul;
      oBusy            <= (r_state != ST_IDLE);
      oPassDone        <= r_tail_done;
      oSampleMiss      <= iEnSample600k && (r_state != ST_IDLE);
    end
  end

endmodule

// File: tb/tb_fir_seq_ctrl.sv
// Bench for fir_seq_ctrl: timestamped expectations queued at stimulus time, popped by a negedge monitor.
module tb_fir_seq_ctrl;
  localparam int TAPS = 10;
  localparam int TAP_W = 4;
  localparam int BANK_W = 2;
  localparam int K_EM = 0, K_EA = 1, K_PASS = 2, K_ACK = 3, K_MISS = 4, K_FLAG = 5, K_BUSY = 6, K_RDY = 7;

  typedef struct {
    int cyc;
    bit wr;
    int addr;
    int dat;
  } ram_t;

  logic              clk = 1'b0;
  logic              iRsn, iEnSample600k, iUpdReq, iCoeffWrValid;
  logic [BANK_W-1:0] iBankSel, iUpdBank;
  logic [15:0]       iCoeffWrData;
  logic              oCoeffWrReady, oUpdAck, oCoeffUpdateFlag, oCsnRam, oWrnRam;
  logic [BANK_W+TAP_W-1:0] oAddrRam;
  logic [15:0]       oWtDtRam;
  logic              oEnMul, oEnAddAcc, oBusy, oPassDone, oSampleMiss;

  int    nvec = 0;
  int    nerr = 0;
  int    cyc = 0;
  bit    mon_en = 1'b0;
  int    q_ev[8][$];
  ram_t  q_ram[$];
  logic [15:0] wbuf[TAPS];
  string kname[8] = '{"en_mul", "en_add_acc", "pass_done", "upd_ack", "sample_miss", "upd_flag", "busy", "wr_ready"};

  fir_seq_ctrl #(.TAPS(TAPS), .TAP_W(TAP_W), .BANK_W(BANK_W)) dut (
    .iClk12M(clk), .iRsn(iRsn), .iEnSample600k(iEnSample600k), .iBankSel(iBankSel),
    .iUpdReq(iUpdReq), .iUpdBank(iUpdBank), .iCoeffWrValid(iCoeffWrValid), .iCoeffWrData(iCoeffWrData),
    .oCoeffWrReady(oCoeffWrReady), .oUpdAck(oUpdAck), .oCoeffUpdateFlag(oCoeffUpdateFlag),
    .oCsnRam(oCsnRam), .oWrnRam(oWrnRam), .oAddrRam(oAddrRam), .oWtDtRam(oWtDtRam),
    .oEnMul(oEnMul), .oEnAddAcc(oEnAddAcc), .oBusy(oBusy), .oPassDone(oPassDone), .oSampleMiss(oSampleMiss)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: every event the DUT shows must match the front of its expectation queue.
  always @(negedge clk) begin
    logic [7:0] act;
    ram_t e;
    if (mon_en) begin
      act = {oCoeffWrReady, oBusy, oCoeffUpdateFlag, oSampleMiss, oUpdAck, oPassDone, oEnAddAcc, oEnMul};
      for (int k = 0; k < 8; k++) begin
        while (q_ev[k].size() > 0 && q_ev[k][0] < cyc) begin
          nvec++; nerr++;
          $display("FAIL %s missed: low at edge %0d, required high", kname[k], q_ev[k][0]);
          void'(q_ev[k].pop_front());
        end
        if (act[k] === 1'b1) begin
          nvec++;
          if (q_ev[k].size() > 0 && q_ev[k][0] == cyc) void'(q_ev[k].pop_front());
          else begin
            nerr++;
            $display("FAIL %s unexpected: high at edge %0d, required low", kname[k], cyc);
          end
        end
      end
      while (q_ram.size() > 0 && q_ram[0].cyc < cyc) begin
        nvec++; nerr++;
        $display("FAIL ram missed: no access at edge %0d, required wr=%0d addr=%0h", q_ram[0].cyc, q_ram[0].wr, q_ram[0].addr);
        void'(q_ram.pop_front());
      end
      if (oCsnRam === 1'b0) begin
        nvec++;
        if (q_ram.size() == 0 || q_ram[0].cyc != cyc) begin
          nerr++;
          $display("FAIL ram unexpected: access at edge %0d wrn=%0b addr=%0h, required none", cyc, oWrnRam, oAddrRam);
        end else begin
          e = q_ram.pop_front();
          if ((e.wr != !oWrnRam) || (e.addr != int'(oAddrRam)) || (e.wr && e.dat != int'(oWtDtRam))) begin
            nerr++;
            $display("FAIL ram access edge %0d: got wr=%0b addr=%0h dat=%0h, required wr=%0b addr=%0h dat=%0h",
                     cyc, !oWrnRam, oAddrRam, oWtDtRam, e.wr, e.addr, e.dat);
          end
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) tick();
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h, required %0h", nm, act, exp);
    end
  endtask

  task automatic push_rng(input int k, input int a, input int b);
    for (int c = a; c <= b; c++) q_ev[k].push_back(c);
  endtask

  task automatic push_ram(input int c, input bit wr, input int addr, input int dat);
    ram_t e;
    e.cyc = c; e.wr = wr; e.addr = addr; e.dat = dat;
    q_ram.push_back(e);
  endtask

  // Reference for a filter pass accepted at edge T; ntap < TAPS models a pass cut by reset.
  task automatic pred_pass(input int T, input int b, input int ntap);
    for (int k = 0; k < ntap; k++) push_ram(T + 1 + k, 1'b0, b * (1 << TAP_W) + k, 0);
    push_rng(K_BUSY, T + 1, T + ntap + ((ntap == TAPS) ? 2 : 0));
    push_rng(K_EM, T + 2, T + ntap + ((ntap == TAPS) ? 1 : 0));
    push_rng(K_EA, T + 3, T + ntap + ((ntap == TAPS) ? 2 : 0));
    if (ntap == TAPS) q_ev[K_PASS].push_back(T + TAPS + 3);
  endtask

  task automatic strobe_now(input logic [BANK_W-1:0] b);
    iEnSample600k = 1'b1;
    iBankSel = b;
    tick();
    iEnSample600k = 1'b0;
    iBankSel = BANK_W'($urandom);
  endtask

  // Update granted at edge U; mode 0 = no stalls, 1 = valid every other cycle, 2 = random stalls.
  task automatic run_update(input int b, input int mode, input int miss_off, input int U);
    bit vpat[64];
    int acc_e[TAPS];
    int n, j, idx, e_last;
    n = 0; j = 0;
    while (n < TAPS) begin
      if (mode == 0)      vpat[j] = 1'b1;
      else if (mode == 1) vpat[j] = (j % 2 == 0);
      else                vpat[j] = (j >= 40) || ($urandom_range(0, 2) != 0);
      if (vpat[j]) begin acc_e[n] = U + 2 + j; n++; end
      j++;
    end
    e_last = acc_e[TAPS-1];
    q_ev[K_ACK].push_back(U);
    push_rng(K_FLAG, U + 1, e_last + 3);
    push_rng(K_BUSY, U + 1, e_last + 3);
    push_rng(K_RDY, U + 1, e_last - 1);
    for (int i = 0; i < TAPS; i++) push_ram(acc_e[i] + 1, 1'b1, b * (1 << TAP_W) + i, int'(wbuf[i]));
    if (miss_off >= 0) q_ev[K_MISS].push_back(U + miss_off);
    while (cyc < U) tick();
    iUpdReq = 1'b0;
    iUpdBank = BANK_W'($urandom);
    tick();
    idx = 0;
    for (int jj = 0; jj < j; jj++) begin
      iCoeffWrValid = vpat[jj];
      iCoeffWrData = vpat[jj] ? wbuf[idx] : 16'($urandom);
      if (vpat[jj]) idx++;
      iEnSample600k = (miss_off >= 0) && (cyc + 1 == U + miss_off);
      tick();
    end
    iCoeffWrValid = 1'b0;
    iEnSample600k = 1'b0;
    idle(6);
  endtask

  task automatic update_now(input int b, input int mode, input int miss_off);
    iUpdReq = 1'b1;
    iUpdBank = BANK_W'(b);
    run_update(b, mode, miss_off, cyc + 1);
  endtask

  initial begin
    int T, b;
    iRsn = 1'b0; iEnSample600k = 1'b0; iBankSel = '0; iUpdReq = 1'b0; iUpdBank = '0;
    iCoeffWrValid = 1'b0; iCoeffWrData = '0;
    idle(3);
    chk("rst_csn", oCsnRam, 1); chk("rst_wrn", oWrnRam, 1); chk("rst_addr", oAddrRam, 0);
    chk("rst_wdat", oWtDtRam, 0); chk("rst_busy", oBusy, 0); chk("rst_flag", oCoeffUpdateFlag, 0);
    chk("rst_rdy", oCoeffWrReady, 0); chk("rst_enmul", oEnMul, 0); chk("rst_enacc", oEnAddAcc, 0);
    iRsn = 1'b1;
    tick();
    mon_en = 1'b1;

    T = cyc + 1; pred_pass(T, 1, TAPS); strobe_now(2'd1); idle(15);

    for (int i = 0; i < TAPS; i++) wbuf[i] = 16'h0A00 + 16'(i);
    update_now(0, 0, -1);
    for (int i = 0; i < TAPS; i++) wbuf[i] = 16'($urandom);
    update_now(1, 1, -1);
    for (int i = 0; i < TAPS; i++) wbuf[i] = 16'($urandom);
    update_now(int'($urandom_range(0, 3)), 0, 5);

    // Strobe and request together: pass first, grant one cycle after pass-done.
    for (int i = 0; i < TAPS; i++) wbuf[i] = 16'($urandom);
    b = int'($urandom_range(0, 3));
    T = cyc + 1; pred_pass(T, b, TAPS);
    iUpdReq = 1'b1; iUpdBank = 2'd2;
    strobe_now(BANK_W'(b));
    run_update(2, 0, -1, T + TAPS + 4);

    for (int s = 0; s < 20; s++) begin
      b = int'($urandom_range(0, 3));
      T = cyc + 1; pred_pass(T, b, TAPS); strobe_now(BANK_W'(b)); idle(19);
    end

    for (int r = 0; r < 4; r++) begin
      b = int'($urandom_range(0, 3));
      if ($urandom_range(0, 1) == 1) begin
        T = cyc + 1; pred_pass(T, b, TAPS); strobe_now(BANK_W'(b)); idle(15);
      end else begin
        for (int i = 0; i < TAPS; i++) wbuf[i] = 16'($urandom);
        update_now(b, 2, -1);
      end
    end

    // Reset while tap 5 is on the bus.
    T = cyc + 1; pred_pass(T, 3, 6); strobe_now(2'd3);
    idle(6);
    iRsn = 1'b0;
    tick();
    chk("midrst_csn", oCsnRam, 1); chk("midrst_enmul", oEnMul, 0); chk("midrst_enacc", oEnAddAcc, 0);
    chk("midrst_addr", oAddrRam, 0); chk("midrst_busy", oBusy, 0);
    iRsn = 1'b1;
    idle(20);

    mon_en = 1'b0;
    for (int k = 0; k < 8; k++) chk({"left_", kname[k]}, q_ev[k].size(), 0);
    chk("left_ram", q_ram.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule

// File: doc/fir_seq_ctrl.md
# fir_seq_ctrl

Sequencer for the reconfigurable FIR datapath: converts the 600 kHz sample strobe into the per-sample coefficient-RAM read burst and the EnMul/EnAddAcc pipeline enables. It also runs the coefficient-update protocol (update flag, RAM write burst) for a requester over a valid/ready handshake. It sits between the system/host logic and the FIR core and drives every RAM and enable input of the core except the sample data.

## Interface
- TAPS, 10, taps per coefficient bank (2..2^TAP_W)
- TAP_W, 4, tap-index width (low address bits)
- BANK_W, 2, bank-select width (high address bits); RAM address width = BANK_W+TAP_W
- iClk12M  in  1  12 MHz clock; the only clock
- iRsn  in  1  reset; one clock; synchronous, active-low
- iEnSample600k  in  1  one-cycle sample strobe
- iBankSel  in  BANK_W  coefficient bank used for filtering; latched on accepted strobe
- iUpdReq  in  1  level update request; held until oUpdAck
- iUpdBank  in  BANK_W  bank to rewrite; latched with oUpdAck
- iCoeffWrValid  in  1  coefficient word valid
- iCoeffWrData  in  16  coefficient word
- oCoeffWrReady  out  1  controller accepts a word this cycle
- oUpdAck  out  1  one-cycle pulse: update request accepted
- oCoeffUpdateFlag  out  1  to core iCoeffUpdateFlag
- oCsnRam, oWrnRam  out  1 each  RAM chip-select / write strobe, active-low
- oAddrRam  out  BANK_W+TAP_W  {bank, tap}
- oWtDtRam  out  16  RAM write data
- oEnMul, oEnAddAcc  out  1 each  core pipeline enables
- oBusy  out  1  state ≠ IDLE
- oPassDone  out  1  one-cycle pulse at end of a filter pass
- oSampleMiss  out  1  one-cycle pulse: strobe dropped

## Operation
- All outputs registered. Reset: oCsnRam=1, oWrnRam=1, oAddrRam=0, oWtDtRam=0, all other outputs 0, state IDLE, counters 0.
- States: IDLE, RUN, TAIL, UPD_PRE, UPD_WR, UPD_POST.
- IDLE: strobe → latch iBankSel, RUN, tap=0. Else iUpdReq → oUpdAck pulse, latch iUpdBank, UPD_PRE. Strobe and iUpdReq same cycle: strobe wins; request stays pending.
- RUN: oCsnRam=0, oWrnRam=1, oAddrRam={bank,tap}, tap 0..TAPS-1, one per cycle; after TAPS-1 → TAIL.
- TAIL: 2 cycles, oCsnRam=1, oAddrRam=0; then IDLE with oPassDone.
- oEnMul = RUN delayed 1 cycle; oEnAddAcc = RUN delayed 2 cycles.
- UPD_PRE: oCoeffUpdateFlag=1, RAM idle, 1 cycle → UPD_WR, wcnt=0.
- UPD_WR: oCoeffWrReady=1 while wcnt<TAPS. Accepted word (valid&ready) → next cycle oCsnRam=0, oWrnRam=0, oAddrRam={updbank,wcnt}, oWtDtRam=data, wcnt++. Cycles without acceptance: oCsnRam=oWrnRam=1. Stalls unbounded. After TAPS-th acceptance, ready drops same edge → UPD_POST.
- UPD_POST: 3 cycles: first = last write strobe, then 2 cycles flag high with RAM idle; flag drops entering IDLE.
- Strobe in any non-IDLE state: dropped, oSampleMiss pulses next cycle; no queuing.
- iBankSel/iUpdBank changes after latching: ignored until next acceptance.
- iRsn low in any state: next edge returns to reset values; partial write burst abandoned, no further RAM strobes.

## Timing
- Strobe sampled high at edge T: tap k address on bus after edge T+1+k, k=0..TAPS-1 (oCsnRam low T+1..T+TAPS).
- oEnMul high T+2..T+TAPS+1; oEnAddAcc high T+3..T+TAPS+2.
- oPassDone pulse after edge T+TAPS+3; oBusy high T+1..T+TAPS+2.
- Pass length TAPS+3 = 13 cycles (default) < 20-cycle sample period: back-to-back strobes never miss.
- Update, no stalls: oUpdAck edge U; flag high U+1..U+TAPS+4; write strobes U+3..U+TAPS+2.
- oCsnRam and oWrnRam never low outside RUN/UPD_WR/UPD_POST; oWrnRam never low in RUN.

## Test plan
- Reset mid-RUN (tap 5): next edge oCsnRam=1, oEnMul=0, oEnAddAcc=0, oAddrRam=0, oBusy=0.
- Strobe, iBankSel=1: addresses 0x10..0x19 on consecutive cycles T+1..T+10, oEnMul T+2..T+11, oEnAddAcc T+3..T+12, oPassDone at T+13.
- iUpdReq, bank 0, words 0xA00..0xA09 no stalls: ten write strobes at addresses 0x00..0x09 with matching data, flag high 14 cycles, oUpdAck once.
- Same update, bank 1, iCoeffWrValid low every other cycle: writes 0x10..0x19 land in order, oCsnRam high during gaps, no duplicate writes.
- Strobe while in UPD_WR: oSampleMiss pulse, no read strobe, write burst completes unchanged.
- Strobe and iUpdReq same cycle in IDLE: filter pass runs first; oUpdAck in the cycle after oPassDone; 20 continuous strobes produce 20 oPassDone, 0 oSampleMiss.
